byte_lane_dly_loader: RTL and testbench
=======================================

Name: byte_lane_dly_loader

Overview:
- Initiator side of the byte-lane delay programming interface.
- Holds a shadow copy of every IDELAY/ODELAY value for 2**LANE_BITS byte lanes. On command, it streams the selected values into the lanes over the shared dly_data/dly_addr bus with per-lane ld_delay strobes, then issues one common set strobe.
- Sits between the software register interface and the PHY byte lanes. Everything runs in the clk_div domain.

Parameters:
- LANE_BITS, 1: log2 of the number of byte lanes; NUM_LANES = 2**LANE_BITS.
- SET_WAIT, 2: idle cycles after set before done, covering lane input-register latency and delay settling.

Ports:
- clk_div, input, 1: clock; all logic is clocked on the rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- wr_en, input, 1: write shadow entry.
- wr_addr, input, LANE_BITS+5: {lane, dly_addr[4:0]} of the shadow entry.
- wr_data, input, 8: delay value; 3 LSBs are the fine delay.
- rd_addr, input, LANE_BITS+5: shadow readback address.
- rd_data, output, 8: shadow readback, registered.
- start, input, 1: begin a load sequence (sampled only in IDLE).
- full, input, 1: sampled with start. 1 = load all entries; 0 = load dirty entries only.
- busy, output, 1: sequence in progress.
- done, output, 1: one-cycle pulse at sequence end.
- dirty_any, output, 1: OR of all dirty bits.
- dly_data, output, 8: delay value to the lanes.
- dly_addr, output, 5: delay select to the lanes; 0-7 DQ out, 8 DQS out, 9 DM out, 16-23 DQ in, 24 DQS in.
- ld_delay, output, 2**LANE_BITS: per-lane load strobe.
- set, output, 1: common set-all-delays strobe.

Behaviour:
- Valid entry addresses are 0-9 and 16-24, giving 19 entries per lane. Writes to addresses 10-15 or 25-31 are dropped, and readback of those addresses returns 0.
- Shadow memory: 19*NUM_LANES x 8 bits. It is not cleared by rst and is initialised to 0 at configuration.
- Dirty bits: one per entry.
  - Set by a write to that entry.
  - Cleared when the entry is issued.
  - rst sets all dirty bits to 1, so the first start after reset loads everything.
- rd_data = shadow[rd_addr], registered, 1-cycle latency.
- Writes are accepted in any state.
- Reset values: busy=0, done=0, ld_delay=0, set=0, dly_addr=0, dly_data=0, rd_data=0, dirty_any=1. All outputs are registered.
- FSM states: IDLE, LOAD, SET, WAIT, DONE.
  - IDLE: start=1 latches full, clears the index, and moves to LOAD. busy rises on the next cycle.
  - LOAD: every entry takes exactly one cycle, whether or not it is issued.
    - Index order: lane 0..NUM_LANES-1 (outer loop); address 0..9 then 16..24 (inner loop).
    - dly_addr and dly_data always show the current entry, with dly_data read from the shadow at issue time.
    - ld_delay[lane] = full | dirty[entry]; all other ld_delay bits are 0.
    - After the last entry, go to SET.
  - SET: set=1 for one cycle, always (even if no entry was issued), ld_delay=0. Go to WAIT.
  - WAIT: SET_WAIT cycles, then DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Timing: let t=0 be the cycle in which start is sampled.
  - Entry i is presented at t=1+i.
  - set is high at t=1+19*NUM_LANES.
  - busy is high for t=1 .. 1+19*NUM_LANES+SET_WAIT.
  - done is high at t=2+19*NUM_LANES+SET_WAIT.
- start while not IDLE is ignored and is not queued.
- Collision: a write to the entry being issued in the same cycle issues the old value, and the dirty bit stays set (the write wins).
- A write to an entry already passed during this sequence sets its dirty bit and is picked up by the next start.
- rst mid-sequence: the FSM returns to IDLE immediately, all strobes drop to 0, and all dirty bits are set. No done pulse is generated.

Test Plan:
- Reset, then start, full=0, LANE_BITS=1, SET_WAIT=2 -> 38 ld_delay pulses at t=1..38.
  - Lane 0 uses ld_delay=01 at t=1..19; lane 1 uses 10 at t=20..38.
  - dly_addr sequence is 0..9,16..24 per lane; set at t=39; busy t=1..41; done t=42; dirty_any=0 afterwards.
- Clean state; write lane1/addr17=0xA5; start, full=0 -> exactly one strobe: ld_delay=10 at t=31 with dly_addr=17 and dly_data=0xA5. set at t=39; done at t=42.
- Clean state; start, full=1 -> 38 strobes, each dly_data equal to the shadow value; rd_addr={1,5'd8} returns the stored value one cycle later.
- Write to addr 12 (0x3C) -> no dirty bit set, dirty_any unchanged, readback returns 0x00. Start again at t=10 during a sequence -> ignored, single done at t=42.
- Collision: write lane0/addr3=0x11 at t=4 of a full sequence -> dly_data shows the old value at t=4. dirty_any=1 after done; the next dirty-only start issues 0x11 at t=4.
- rst pulse at t=10 of a sequence -> ld_delay, set, busy and done go to 0 immediately, dirty_any=1; the next full=0 start issues all 38 entries.

Source files
------------

// File: rtl/byte_lane_dly_loader.sv
// byte_lane_dly_loader: shadows per-lane IDELAY/ODELAY values and streams them into the byte lanes
module byte_lane_dly_loader #(
  parameter int LANE_BITS = 1,
  parameter int SET_WAIT  = 2
) (
  input  logic                     clk_div,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [LANE_BITS+4:0]     wr_addr,
  input  logic [7:0]               wr_data,
  input  logic [LANE_BITS+4:0]     rd_addr,
  output logic [7:0]               rd_data,
  input  logic                     start,
  input  logic                     full,
  output logic                     busy,
  output logic                     done,
  output logic                     dirty_any,
  output logic [7:0]               dly_data,
  output logic [4:0]               dly_addr,
  output logic [2**LANE_BITS-1:0]  ld_delay,
  output logic                     set
);
  localparam int NL = 2**LANE_BITS;
  localparam int NE = 19 * NL;
  localparam int EW = $clog2(NE);
  localparam int CW = SET_WAIT > 1 ? $clog2(SET_WAIT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SET, S_WAIT, S_DONE} state_t;

  function automatic logic [EW-1:0] flat(input logic [LANE_BITS-1:0] lane, input logic [4:0] sub);
    return EW'(32'(lane) * 19 + 32'(sub));
  endfunction

  function automatic logic valid(input logic [4:0] a);
    return a < 5'd10 || (a >= 5'd16 && a <= 5'd24);
  endfunction

  function automatic logic [4:0] sub_of(input logic [4:0] a);
    return a < 5'd10 ? a : a - 5'd6;
  endfunction

  state_t               state_q, state_d;
  logic [LANE_BITS-1:0] lane_q, lane_d;
  logic [4:0]           sub_q, sub_d;
  logic                 full_q, full_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NE-1:0]        dirty_q, dirty_d;
  logic [7:0]           mem_q [NE];
  logic [7:0]           rd_q, data_q;
  logic [4:0]           addr_q;
  logic [NL-1:0]        ld_q;
  logic                 busy_q, done_q, set_q, dirty_any_q;
  logic                 wr_ok, hit;
  logic [EW-1:0]        wr_idx, rd_idx, cur, nxt;

  assign wr_ok  = wr_en && valid(wr_addr[4:0]);
  assign wr_idx = flat(wr_addr[LANE_BITS+4:5], sub_of(wr_addr[4:0]));
  assign rd_idx = flat(rd_addr[LANE_BITS+4:5], sub_of(rd_addr[4:0]));
  assign cur    = flat(lane_q, sub_q);
  assign nxt    = flat(lane_d, sub_d);
  assign hit    = wr_ok && wr_idx == nxt;

  assign rd_data   = rd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign set       = set_q;
  assign dirty_any = dirty_any_q;
  assign dly_data  = data_q;
  assign dly_addr  = addr_q;
  assign ld_delay  = ld_q;

  // Sequencer: walk lanes (outer) and the 19 valid addresses (inner), then set, settle, done
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    sub_d   = sub_q;
    full_d  = full_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LOAD;
        lane_d  = '0;
        sub_d   = '0;
        full_d  = full;
      end
      S_LOAD: if (sub_q == 5'd18) begin
        sub_d = '0;
        if (lane_q == LANE_BITS'(NL - 1)) state_d = S_SET;
        else lane_d = lane_q + 1'b1;
      end else sub_d = sub_q + 5'd1;
      S_SET: begin
        state_d = SET_WAIT == 0 ? S_DONE : S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: if (cnt_q == CW'(SET_WAIT - 1)) state_d = S_DONE;
              else cnt_d = cnt_q + 1'b1;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Issuing an entry clears its dirty bit; a write landing in that same cycle keeps it set
  always_comb begin
    dirty_d = dirty_q;
    if (state_q == S_LOAD) dirty_d[cur] = 1'b0;
    if (wr_ok) dirty_d[wr_idx] = 1'b1;
  end

  // Shadow memory has no reset so programmed delays survive rst
  always_ff @(posedge clk_div)
    if (wr_ok) mem_q[wr_idx] <= wr_data;

  // State and lane-bus outputs; the next entry is fetched one cycle ahead, with write bypass, so it is on the bus in its slot
  always_ff @(posedge clk_div or posedge rst)
    if (rst) begin
      state_q     <= S_IDLE;
      lane_q      <= '0;
      sub_q       <= '0;
      full_q      <= 1'b0;
      cnt_q       <= '0;
      dirty_q     <= '1;
      dirty_any_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      set_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      ld_q        <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      sub_q       <= sub_d;
      full_q      <= full_d;
      cnt_q       <= cnt_d;
      dirty_q     <= dirty_d;
      dirty_any_q <= |dirty_d;
      busy_q      <= state_d inside {S_LOAD, S_SET, S_WAIT};
      done_q      <= state_d == S_DONE;
      set_q       <= state_d == S_SET;
      addr_q      <= state_d != S_LOAD ? 5'd0 : sub_d < 5'd10 ? sub_d : sub_d + 5'd6;
      data_q      <= state_d != S_LOAD ? 8'd0 : hit ? wr_data : mem_q[nxt];
      ld_q        <= state_d == S_LOAD && (full_d || dirty_q[nxt] || hit) ? NL'(1) << lane_d : '0;
      rd_q        <= valid(rd_addr[4:0]) ? mem_q[rd_idx] : 8'd0;
    end
endmodule

// File: tb/tb_byte_lane_dly_loader.sv
// tb_byte_lane_dly_loader: timeline-model checking of the delay loader plus directed corner sequences
module tb_byte_lane_dly_loader;
  localparam int NL = 2;
  localparam int NE = 38;
  localparam int SW = 2;
  localparam int TD = NE + 2 + SW;

  logic       clk_div = 0, rst = 0, wr_en = 0, start = 0, full = 0;
  logic [5:0] wr_addr = 0, rd_addr = 0;
  logic [7:0] wr_data = 0;
  logic [7:0] rd_data, dly_data;
  logic [4:0] dly_addr;
  logic [1:0] ld_delay;
  logic       busy, done, dirty_any, set;

  byte_lane_dly_loader #(.LANE_BITS(1), .SET_WAIT(SW)) dut (
    .clk_div(clk_div), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .start(start), .full(full), .busy(busy),
    .done(done), .dirty_any(dirty_any), .dly_data(dly_data), .dly_addr(dly_addr),
    .ld_delay(ld_delay), .set(set)
  );

  always #5 clk_div = ~clk_div;

  int n_run = 0, n_fail = 0;

  logic [7:0] sh [NL][32];
  bit         dt [NL][32];
  int         seq = -1;
  bit         sfull = 0;
  logic [7:0] erd = 0;

  int         n_ld, t_set, t_done, n_done, t_ld;
  logic [4:0] ld_addr;
  logic [7:0] ld_data, d_at4;
  logic [1:0] ld_val;

  int         inj_t = -2;
  logic       inj_we = 0, inj_st = 0;
  logic [5:0] inj_wa = 0;
  logic [7:0] inj_wd = 0;

  typedef struct {
    logic [5:0] wa;
    logic [7:0] wd;
    logic [7:0] erd;
    logic       eany;
  } vec_t;
  vec_t tbl [13];

  function automatic bit vaddr(input int a);
    return a < 10 || (a >= 16 && a <= 24);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, act, exp, seq);
    end
  endtask

  task automatic check_cycle();
    logic [1:0] eld;
    logic [4:0] ea;
    logic [7:0] ed;
    logic       eb, es, edn, eany;
    bit         ld_phase;
    eld = 0; ea = 0; ed = 0; eb = 0; es = 0; edn = 0; eany = 0;
    ld_phase = seq >= 1 && seq <= NE;
    if (ld_phase) begin
      int i, l, s, a;
      i = seq - 1; l = i / 19; s = i % 19; a = s < 10 ? s : s + 6;
      ea = 5'(a);
      ed = sh[l][a];
      eld = (sfull || dt[l][a]) ? 2'(1 << l) : 2'b00;
      eb = 1;
    end
    es = seq == NE + 1;
    if (seq >= NE + 1 && seq < TD) eb = 1;
    edn = seq == TD;
    for (int l = 0; l < NL; l++)
      for (int a = 0; a < 32; a++) eany |= dt[l][a];
    chk("busy", busy, eb);
    chk("done", done, edn);
    chk("set", set, es);
    chk("ld_delay", ld_delay, eld);
    chk("dirty_any", dirty_any, eany);
    chk("rd_data", rd_data, erd);
    if (ld_phase) begin
      chk("dly_addr", dly_addr, ea);
      chk("dly_data", dly_data, ed);
    end
    if (ld_delay != 0) begin
      n_ld++; t_ld = seq; ld_addr = dly_addr; ld_data = dly_data; ld_val = ld_delay;
    end
    if (set) t_set = seq;
    if (done) begin n_done++; t_done = seq; end
    if (seq == 4) d_at4 = dly_data;
  endtask

  task automatic cyc(input logic we, input logic [5:0] wa, input logic [7:0] wd,
                     input logic [5:0] ra, input logic st, input logic fl);
    check_cycle();
    wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = ra; start = st; full = fl;
    erd = vaddr(int'(ra[4:0])) ? sh[ra[5]][ra[4:0]] : 8'h00;
    if (seq >= 1 && seq <= NE) begin
      int i, s;
      i = seq - 1; s = i % 19;
      dt[i / 19][s < 10 ? s : s + 6] = 0;
    end
    if (we && vaddr(int'(wa[4:0]))) begin
      sh[wa[5]][wa[4:0]] = wd;
      dt[wa[5]][wa[4:0]] = 1;
    end
    if (seq < 0) begin
      if (st) begin seq = 1; sfull = fl; end
    end else seq = seq == TD ? -1 : seq + 1;
    @(negedge clk_div);
  endtask

  task automatic do_reset();
    rst = 1; wr_en = 0; start = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_set", set, 0);
    chk("rst_ld", ld_delay, 0);
    chk("rst_dirty_any", dirty_any, 1);
    chk("rst_rd", rd_data, 0);
    chk("rst_dly_addr", dly_addr, 0);
    chk("rst_dly_data", dly_data, 0);
    seq = -1; erd = 0;
    for (int l = 0; l < NL; l++)
      for (int a = 0; a < 32; a++) dt[l][a] = vaddr(a);
    @(negedge clk_div);
    rst = 0;
  endtask

  task automatic run_seq(input logic fl);
    n_ld = 0; t_set = -1; t_done = -1; n_done = 0; t_ld = -1;
    cyc(0, 0, 0, rd_addr, 1, fl);
    while (seq >= 0) begin
      if (seq == inj_t) cyc(inj_we, inj_wa, inj_wd, rd_addr, inj_st, fl);
      else cyc(0, 0, 0, rd_addr, 0, 0);
    end
    inj_t = -2;
    cyc(0, 0, 0, rd_addr, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{6'd12, 8'h3C, 8'h00, 1'b0};
    tbl[1]  = '{6'd10, 8'h55, 8'h00, 1'b0};
    tbl[2]  = '{6'd15, 8'h66, 8'h00, 1'b0};
    tbl[3]  = '{6'd25, 8'h77, 8'h00, 1'b0};
    tbl[4]  = '{6'd31, 8'h88, 8'h00, 1'b0};
    tbl[5]  = '{6'd45, 8'h99, 8'h00, 1'b0};
    tbl[6]  = '{6'd58, 8'hAA, 8'h00, 1'b0};
    tbl[7]  = '{6'd0,  8'h12, 8'h12, 1'b1};
    tbl[8]  = '{6'd9,  8'h34, 8'h34, 1'b1};
    tbl[9]  = '{6'd16, 8'h56, 8'h56, 1'b1};
    tbl[10] = '{6'd24, 8'h78, 8'h78, 1'b1};
    tbl[11] = '{6'd40, 8'h9A, 8'h9A, 1'b1};
    tbl[12] = '{6'd49, 8'hBC, 8'hBC, 1'b1};

    @(negedge clk_div);
    do_reset();
    for (int l = 0; l < NL; l++)
      for (int a = 0; a < 32; a++)
        if (vaddr(a)) cyc(1, {1'(l), 5'(a)}, 8'($urandom), 0, 0, 0);

    run_seq(0);
    chk("t1_n_ld", n_ld, 38);
    chk("t1_set_t", t_set, 39);
    chk("t1_done_t", t_done, 42);
    chk("t1_dirty_any", dirty_any, 0);

    foreach (tbl[k]) begin
      cyc(1, tbl[k].wa, tbl[k].wd, rd_addr, 0, 0);
      cyc(0, 0, 0, tbl[k].wa, 0, 0);
      chk("tbl_rd", rd_data, tbl[k].erd);
      chk("tbl_dirty_any", dirty_any, tbl[k].eany);
    end
    run_seq(0);

    cyc(1, {1'b1, 5'd17}, 8'hA5, rd_addr, 0, 0);
    run_seq(0);
    chk("t2_n_ld", n_ld, 1);
    chk("t2_ld_t", t_ld, 31);
    chk("t2_ld_val", ld_val, 2'b10);
    chk("t2_ld_addr", ld_addr, 17);
    chk("t2_ld_data", ld_data, 8'hA5);
    chk("t2_set_t", t_set, 39);
    chk("t2_done_t", t_done, 42);

    run_seq(1);
    chk("t3_n_ld", n_ld, 38);
    cyc(0, 0, 0, {1'b1, 5'd8}, 0, 0);
    chk("t3_rd_l1_a8", rd_data, 8'h9A);

    inj_t = 10; inj_we = 1; inj_wa = 6'd12; inj_wd = 8'h3C; inj_st = 1;
    run_seq(0);
    chk("t4_n_done", n_done, 1);
    chk("t4_done_t", t_done, 42);
    chk("t4_dirty_any", dirty_any, 0);

    cyc(1, 6'd3, 8'h5A, rd_addr, 0, 0);
    run_seq(0);
    inj_t = 4; inj_we = 1; inj_wa = 6'd3; inj_wd = 8'h11; inj_st = 0;
    run_seq(1);
    chk("t5_old_at4", d_at4, 8'h5A);
    chk("t5_dirty_any", dirty_any, 1);
    run_seq(0);
    chk("t5_n_ld", n_ld, 1);
    chk("t5_ld_t", t_ld, 4);
    chk("t5_ld_data", ld_data, 8'h11);

    cyc(0, 0, 0, rd_addr, 1, 0);
    while (seq >= 0 && seq < 10) cyc(0, 0, 0, rd_addr, 0, 0);
    do_reset();
    run_seq(0);
    chk("t6_n_ld", n_ld, 38);
    chk("t6_n_done", n_done, 1);

    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(0, 10);
      for (int k = 0; k < n; k++)
        cyc($urandom_range(0, 1) == 1, 6'($urandom), 8'($urandom), 6'($urandom), 0, 0);
      inj_t = $urandom_range(1, TD); inj_we = 1; inj_wa = 6'($urandom);
      inj_wd = 8'($urandom); inj_st = $urandom_range(0, 1) == 1;
      run_seq($urandom_range(0, 1) == 1);
      chk("rnd_n_done", n_done, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
